// File: rtl/pc_gen.sv
// pc_gen: program-counter / next-PC generator for the instruction-fetch port.
//
// The PC advances by STEP only when fetch accepts the current PC.
// Trap redirects take priority over branch redirects, which take priority over
// sequential advance. A misaligned branch target parks the generator in ERR
// until a trap arrives.
//
// Optional feature macro: PC_TRACE_EN (adds a ring of recently fetched PCs).
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   stall           suppresses fetch_valid while running; PC holds
//   halt            request to enter / remain in HALT
//   redirect_valid  branch/jump redirect strobe, target on redirect_pc
//   trap_valid      trap redirect strobe, vector on trap_pc
//   fetch_ready     fetch side accepts pc this cycle
//   fetch_valid     pc is a valid fetch request
//   pc              current PC (registered)
//   misalign        redirect target was misaligned; generator parked in ERR
//   fetch_cnt       number of accepted fetches (wraps)
//   trace_idx       trace read index, 0 = newest          (PC_TRACE_EN only)
//   trace_pc        PC fetched trace_idx fires ago        (PC_TRACE_EN only)
module pc_gen #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] START_ADDR  = 32'h8000_0000,
  parameter int              STEP        = 4,
  parameter int              ALIGN_BITS  = 2,
  parameter int              CNT_W       = 32,
  parameter int              TRACE_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             halt,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             trap_valid,
  input  logic [XLEN-1:0]  trap_pc,
  input  logic             fetch_ready,
  output logic             fetch_valid,
  output logic [XLEN-1:0]  pc,
  output logic             misalign,
  output logic [CNT_W-1:0] fetch_cnt
`ifdef PC_TRACE_EN
  ,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
  output logic [XLEN-1:0]                trace_pc
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // Low-order bits that must be zero in a legal target; all-zero when ALIGN_BITS is 0.
  localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1'b1) << ALIGN_BITS) - XLEN'(1'b1);

  state_t            state_r, state_s;
  logic [XLEN-1:0]   pc_r, pc_s;
  logic              misalign_r, misalign_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              fire_s;
  logic              redir_take_s;
  logic              redir_bad_s;

  assign fetch_valid  = (state_r == ST_RUN) & ~stall;
  assign fire_s       = fetch_valid & fetch_ready;
  // Redirects only matter while running or halted; BOOT and ERR ignore them.
  assign redir_take_s = redirect_valid & ((state_r == ST_RUN) | (state_r == ST_HALT));
  assign redir_bad_s  = |(redirect_pc & ALIGN_MASK);

  assign pc        = pc_r;
  assign misalign  = misalign_r;
  assign fetch_cnt = cnt_r;

  // Next-state / next-PC selection: trap > redirect > sequential advance > hold.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    misalign_s = misalign_r;
    if (trap_valid) begin
      pc_s       = trap_pc & ~ALIGN_MASK;
      state_s    = ST_RUN;
      misalign_s = 1'b0;
    end else if (redir_take_s) begin
      // A legal redirect keeps the current state, so a redirect in HALT stays halted.
      pc_s = redirect_pc;
      if (redir_bad_s) begin
        state_s    = ST_ERR;
        misalign_s = 1'b1;
      end else begin
        state_s    = state_r;
        misalign_s = misalign_r;
      end
    end else begin
      // A fire in the cycle that requests HALT still advances the PC.
      if (fire_s) begin
        pc_s = pc_r + XLEN'(STEP);
      end else begin
        pc_s = pc_r;
      end
      case (state_r)
        ST_BOOT: state_s = ST_RUN;
        ST_RUN:  state_s = halt ? ST_HALT : ST_RUN;
        ST_HALT: state_s = halt ? ST_HALT : ST_RUN;
        ST_ERR:  state_s = ST_ERR;
        default: state_s = ST_BOOT;
      endcase
    end
  end

  // State, PC and misalign flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_BOOT;
      pc_r       <= START_ADDR;
      misalign_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      misalign_r <= misalign_s;
    end
  end

  // Accepted-fetch counter; counts every fire, including one that coincides with a redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (fire_s) begin
      cnt_r <= cnt_r + CNT_W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

`ifdef PC_TRACE_EN
  localparam int TW = $clog2(TRACE_DEPTH);

  logic [XLEN-1:0] trace_mem_r [TRACE_DEPTH];
  logic [TW-1:0]   wr_ptr_r;
  logic [TW-1:0]   rd_ptr_s;

  // Newest entry sits just behind the write pointer; older entries further back.
  assign rd_ptr_s = wr_ptr_r - TW'(1'b1) - trace_idx;
  assign trace_pc = trace_mem_r[rd_ptr_s];

  // Trace ring: write the fired PC and advance, overwriting the oldest entry when full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {TW{1'b0}};
      for (int i = 0; i < TRACE_DEPTH; i++) begin
        trace_mem_r[i] <= {XLEN{1'b0}};
      end
    end else if (fire_s) begin
      trace_mem_r[wr_ptr_r] <= pc_r;
      wr_ptr_r              <= wr_ptr_r + TW'(1'b1);
    end else begin
      wr_ptr_r <= wr_ptr_r;
    end
  end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: self-checking bench for pc_gen.
// Directed scenarios plus randomized stimulus compared against a behavioural
// model of the PC generator's rules. A second instance with START_ADDR at the
// top of the address space checks PC wrap-around.
module tb_pc_gen;

  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;
  localparam int M_ERR  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_pc = 32'h0;
  logic        fetch_ready = 1'b0;
  logic        fetch_valid;
  logic [31:0] pc;
  logic        misalign;
  logic [31:0] fetch_cnt;

  logic        w_fv;
  logic [31:0] w_pc;
  logic        w_mis;
  logic [31:0] w_cnt;

`ifdef PC_TRACE_EN
  logic [2:0]  trace_idx = 3'd0;
  logic [31:0] trace_pc;
  logic [2:0]  w_tidx = 3'd0;
  logic [31:0] w_tpc;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_st;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_mis;
  logic [31:0] m_trace[$];

  always #5 clk = ~clk;

  pc_gen u_dut (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .pc(pc), .misalign(misalign), .fetch_cnt(fetch_cnt)
`ifdef PC_TRACE_EN
    , .trace_idx(trace_idx), .trace_pc(trace_pc)
`endif
  );

  pc_gen #(.START_ADDR(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .stall(1'b0), .halt(1'b0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .trap_valid(1'b0), .trap_pc(32'h0), .fetch_ready(1'b1),
    .fetch_valid(w_fv), .pc(w_pc), .misalign(w_mis), .fetch_cnt(w_cnt)
`ifdef PC_TRACE_EN
    , .trace_idx(w_tidx), .trace_pc(w_tpc)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st  = M_BOOT;
    m_pc  = 32'h8000_0000;
    m_cnt = 32'h0;
    m_mis = 1'b0;
    m_trace.delete();
  endtask

  // One clock of stimulus: drive inputs, check fetch_valid, advance model, check registered outputs.
  task automatic cyc(input logic st, input logic hl, input logic rv, input logic [31:0] rpc,
                     input logic tv, input logic [31:0] tpc, input logic fr);
    bit fv_exp;
    bit fire;
    stall = st; halt = hl; redirect_valid = rv; redirect_pc = rpc;
    trap_valid = tv; trap_pc = tpc; fetch_ready = fr;
    #1;
    fv_exp = (m_st == M_RUN) && !st;
    chk("fetch_valid", fetch_valid, fv_exp);
    fire = fv_exp && fr;
    if (fire) begin
      m_cnt = m_cnt + 32'd1;
      m_trace.push_back(m_pc);
    end
    if (tv) begin
      m_pc  = tpc - (tpc % 32'd4);
      m_st  = M_RUN;
      m_mis = 1'b0;
    end else if (rv && (m_st == M_RUN || m_st == M_HALT)) begin
      m_pc = rpc;
      if (rpc % 32'd4 != 32'd0) begin
        m_st  = M_ERR;
        m_mis = 1'b1;
      end
    end else begin
      if (fire) m_pc = m_pc + 32'd4;
      if (m_st == M_BOOT) m_st = M_RUN;
      else if (m_st != M_ERR) m_st = hl ? M_HALT : M_RUN;
    end
    @(posedge clk);
    #1;
    chk("pc", pc, m_pc);
    chk("misalign", misalign, m_mis);
    chk("fetch_cnt", fetch_cnt, m_cnt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    model_reset();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    int          budget;
    model_reset();
    // Reset state
    #22;
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_fv", fetch_valid, 1'b0);
    chk("rst_mis", misalign, 1'b0);
    chk("rst_cnt", fetch_cnt, 32'h0);
    rst = 1'b0;

    // BOOT cycle, then three accepted fetches
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("boot_pc_hold", pc, 32'h8000_0000);
    chk("wrap_boot_pc", w_pc, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("wrap_pc", w_pc, 32'h0000_0000);
    chk("wrap_fv", w_fv, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("seq_pc", pc, 32'h8000_000C);
    chk("seq_cnt", fetch_cnt, 32'd3);

    // Fetch not ready: PC holds
    do_reset();
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    chk("hold_pc", pc, 32'h8000_0000);
    chk("hold_cnt", fetch_cnt, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("adv_pc", pc, 32'h8000_0004);

    // Redirect together with a fire
    cyc(0, 0, 1, 32'h8000_0100, 0, 0, 1);
    chk("redir_pc", pc, 32'h8000_0100);
    chk("redir_cnt", fetch_cnt, 32'd2);

    // Misaligned redirect parks in ERR; redirects ignored; trap recovers
    cyc(0, 0, 1, 32'h8000_0102, 0, 0, 1);
    chk("mis_pc", pc, 32'h8000_0102);
    chk("mis_flag", misalign, 1'b1);
    cyc(0, 0, 1, 32'h8000_0200, 0, 0, 1);
    chk("err_ignore_pc", pc, 32'h8000_0102);
    cyc(0, 1, 0, 0, 1, 32'h8000_0403, 1);
    chk("trap_pc", pc, 32'h8000_0400);
    chk("trap_mis", misalign, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Trap beats redirect
    cyc(0, 0, 1, 32'h8000_0100, 1, 32'h8000_0040, 1);
    chk("prio_pc", pc, 32'h8000_0040);

    // HALT entry with a fire, redirect inside HALT, then async reset mid-HALT
    cyc(0, 1, 0, 0, 0, 0, 1);
    chk("halt_entry_pc", pc, 32'h8000_0044);
    cyc(0, 1, 1, 32'h8000_0300, 0, 0, 1);
    chk("halt_redir_pc", pc, 32'h8000_0300);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("halt_still_pc", pc, 32'h8000_0300);
    halt = 1'b1;
    rst  = 1'b1;
    #1;
    chk("async_rst_pc", pc, 32'h8000_0000);
    chk("async_rst_fv", fetch_valid, 1'b0);
    model_reset();
    #4;
    rst = 1'b0;

    // Randomized stimulus against the model
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
      cyc($urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 7) == 0, r,
          $urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) != 0);
`ifdef PC_TRACE_EN
      trace_idx = 3'($urandom_range(0, 7));
      #1;
      chk("trace_rand", trace_pc,
          (int'(trace_idx) < m_trace.size()) ? m_trace[m_trace.size() - 1 - int'(trace_idx)] : 32'h0);
`endif
    end

`ifdef PC_TRACE_EN
    // Ten fires from reset into an eight-entry ring
    do_reset();
    cyc(0, 0, 0, 0, 0, 0, 1);
    budget = 0;
    while (m_cnt < 32'd10 && budget < 50) begin
      cyc(0, 0, 0, 0, 0, 0, 1);
      budget++;
    end
    chk("trace_budget", (budget < 50), 1'b1);
    trace_idx = 3'd0;
    #1;
    chk("trace_newest", trace_pc, 32'h8000_0024);
    trace_idx = 3'd7;
    #1;
    chk("trace_oldest", trace_pc, 32'h8000_0008);
`else
    budget = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
